// File: rtl/exec_stage.sv
// exec_stage -- two-register execute stage wrapped around an external ALU.
// Stage X holds the issued operation and drives the ALU; stage W captures the
// ALU result and presents it to writeback. The PSR is loaded from the ALU flags
// as an operation moves from X into W.
// Optional feature: define EXEC_FWD_EN to forward in-flight results into the
// operands captured by X (X result first, then W result).

package exec_pkg;
   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_SUB  = 4'h1;
   localparam logic [3:0] OP_AND  = 4'h2;
   localparam logic [3:0] OP_OR   = 4'h3;
   localparam logic [3:0] OP_XOR  = 4'h4;
   localparam logic [3:0] OP_NOT  = 4'h5;
   localparam logic [3:0] OP_SHL  = 4'h6;
   localparam logic [3:0] OP_SHR  = 4'h7;
   localparam logic [3:0] OP_MOV  = 4'h8;
   localparam logic [3:0] OP_CMP  = 4'h9;
   localparam logic [3:0] OP_CMPR = 4'ha;
   localparam logic [3:0] OP_ADDC = 4'hb;
   localparam logic [3:0] OP_SUBC = 4'hc;
   // Codes 4'hd..4'hf are undefined.

   // Opcodes that produce a register result; compares and undefined codes never write.
   function automatic logic op_writes_reg(input logic [3:0] op);
      logic w;
      w = 1'b0;
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT,
         OP_SHL, OP_SHR, OP_MOV, OP_ADDC, OP_SUBC: w = 1'b1;
         default:                                  w = 1'b0;
      endcase
      return w;
   endfunction
endpackage

module exec_stage
   import exec_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   // issue side
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  in_opcode,
   input  logic [15:0] in_a,
   input  logic [15:0] in_b,
   input  logic [3:0]  in_srca,
   input  logic [3:0]  in_srcb,
   input  logic [3:0]  in_dest,
   input  logic        in_wr,
   input  logic        in_wr_psr,
   // ALU side
   output logic [15:0] alu_a,
   output logic [15:0] alu_b,
   output logic [3:0]  alu_opcode,
   input  logic [15:0] alu_c,
   input  logic        alu_flag,
   input  logic        alu_low,
   input  logic        alu_negative,
   input  logic        alu_zero,
   // writeback side
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_result,
   output logic [3:0]  out_dest,
   output logic        out_wr,
   // processor status register
   output logic        psr_flag,
   output logic        psr_low,
   output logic        psr_negative,
   output logic        psr_zero
);

   // Handshake: a transfer happens on any rising edge where valid and ready are
   // both 1. The producer keeps valid and payload stable until that edge; ready
   // may be computed from downstream ready combinationally (never from valid).

   typedef struct packed {
      logic [3:0]  opcode;
      logic [15:0] a;
      logic [15:0] b;
      logic [3:0]  dest;
      logic        wr;
      logic        wr_psr;
   } x_stage_t;

   x_stage_t    x_q;
   logic        x_valid;
   logic        w_valid;
   logic [15:0] w_result;
   logic [3:0]  w_dest;
   logic        w_wr;
   logic [3:0]  psr_q;

   logic        w_advance;
   logic        x_ready;
   logic        x_to_w;
   logic [15:0] op_a;
   logic [15:0] op_b;

   // W drains when empty or accepted; X accepts when empty or draining into W.
   assign w_advance = !w_valid || out_ready;
   assign x_ready   = !x_valid || w_advance;
   assign x_to_w    = w_advance && x_valid;

   // During reset the issue port looks free and nothing is presented.
   assign in_ready  = x_ready || !rst_n;
   assign out_valid = w_valid && rst_n;

`ifdef EXEC_FWD_EN
   logic x_hit_a;
   logic x_hit_b;
   logic w_hit_a;
   logic w_hit_b;

   // Operand forwarding: the result still in X (on alu_c) beats the one in W.
   always_comb begin
      x_hit_a = x_valid && x_q.wr && (x_q.dest == in_srca);
      x_hit_b = x_valid && x_q.wr && (x_q.dest == in_srcb);
      w_hit_a = w_valid && w_wr && (w_dest == in_srca);
      w_hit_b = w_valid && w_wr && (w_dest == in_srcb);
      op_a = in_a;
      op_b = in_b;
      if (x_hit_a)
         op_a = alu_c;
      else if (w_hit_a)
         op_a = w_result;
      if (x_hit_b)
         op_b = alu_c;
      else if (w_hit_b)
         op_b = w_result;
   end
`else
   // Without forwarding the source indices carry no meaning for this stage.
   logic unused_src;
   assign unused_src = ^{in_srca, in_srcb};
   assign op_a = in_a;
   assign op_b = in_b;
`endif

   // Stage X: capture the issue port whenever X is free or draining into W.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         x_valid <= 1'b0;
         x_q     <= '0;
      end else if (x_ready) begin
         x_valid     <= in_valid;
         x_q.opcode  <= in_opcode;
         x_q.a       <= op_a;
         x_q.b       <= op_b;
         x_q.dest    <= in_dest;
         x_q.wr      <= in_wr && op_writes_reg(in_opcode);
         x_q.wr_psr  <= in_wr_psr;
      end
   end

   // Stage W: take the ALU result of X; bubbles only clear w_valid.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         w_valid  <= 1'b0;
         w_result <= 16'h0000;
         w_dest   <= 4'h0;
         w_wr     <= 1'b0;
      end else if (w_advance) begin
         w_valid <= x_valid;
         if (x_valid) begin
            w_result <= alu_c;
            w_dest   <= x_q.dest;
            w_wr     <= x_q.wr;
         end
      end
   end

   // PSR: load ALU flags when a valid operation with wr_psr moves into W.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         psr_q <= 4'h0;
      end else if (x_to_w && x_q.wr_psr) begin
         psr_q <= {alu_flag, alu_low, alu_negative, alu_zero};
      end
   end

   assign alu_a        = x_q.a;
   assign alu_b        = x_q.b;
   assign alu_opcode   = x_q.opcode;

   assign out_result   = w_result;
   assign out_dest     = w_dest;
   assign out_wr       = w_wr;

   assign psr_flag     = psr_q[3];
   assign psr_low      = psr_q[2];
   assign psr_negative = psr_q[1];
   assign psr_zero     = psr_q[0];

endmodule

// File: tb/tb_exec_stage.sv
// tb_exec_stage -- directed and random scenarios for exec_stage with a
// behavioural ALU, a scoreboard queue of expected writeback items and a
// running PSR model. Build with or without EXEC_FWD_EN.

module tb_exec_stage;
   import exec_pkg::*;

`ifdef EXEC_FWD_EN
   localparam bit fwd_on = 1'b1;
`else
   localparam bit fwd_on = 1'b0;
`endif

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_opcode;
   logic [15:0] in_a;
   logic [15:0] in_b;
   logic [3:0]  in_srca;
   logic [3:0]  in_srcb;
   logic [3:0]  in_dest;
   logic        in_wr;
   logic        in_wr_psr;
   logic [15:0] alu_a;
   logic [15:0] alu_b;
   logic [3:0]  alu_opcode;
   logic [15:0] alu_c;
   logic        alu_flag;
   logic        alu_low;
   logic        alu_negative;
   logic        alu_zero;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_result;
   logic [3:0]  out_dest;
   logic        out_wr;
   logic        psr_flag;
   logic        psr_low;
   logic        psr_negative;
   logic        psr_zero;

   int          checks   = 0;
   int          failures = 0;

   // entry: result[24:9] dest[8:5] wr[4] psr{flag,low,neg,zero}[3:0]
   logic [24:0] exp_q[$];
   logic [3:0]  psr_m;

   exec_stage dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_opcode    (in_opcode),
      .in_a         (in_a),
      .in_b         (in_b),
      .in_srca      (in_srca),
      .in_srcb      (in_srcb),
      .in_dest      (in_dest),
      .in_wr        (in_wr),
      .in_wr_psr    (in_wr_psr),
      .alu_a        (alu_a),
      .alu_b        (alu_b),
      .alu_opcode   (alu_opcode),
      .alu_c        (alu_c),
      .alu_flag     (alu_flag),
      .alu_low      (alu_low),
      .alu_negative (alu_negative),
      .alu_zero     (alu_zero),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_result   (out_result),
      .out_dest     (out_dest),
      .out_wr       (out_wr),
      .psr_flag     (psr_flag),
      .psr_low      (psr_low),
      .psr_negative (psr_negative),
      .psr_zero     (psr_zero)
   );

   // ---------------- clock / watchdog ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- behavioural ALU ----------------
   // returns {flag, low, negative, zero, c[15:0]}
   function automatic logic [19:0] alu_ref(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
      logic [16:0] t;
      logic [15:0] c;
      logic        f;
      t = '0;
      c = '0;
      f = 1'b0;
      case (op)
         OP_ADD:         begin t = {1'b0, a} + {1'b0, b}; c = t[15:0]; f = t[16]; end
         OP_SUB, OP_CMP: begin c = a - b; f = (a < b); end
         OP_CMPR:        begin c = b - a; f = (b < a); end
         OP_AND:         c = a & b;
         OP_OR:          c = a | b;
         OP_XOR:         c = a ^ b;
         OP_NOT:         c = ~a;
         OP_SHL:         begin c = {a[14:0], 1'b0}; f = a[15]; end
         OP_SHR:         begin c = {1'b0, a[15:1]}; f = a[0]; end
         OP_MOV:         c = b;
         OP_ADDC:        begin t = {1'b0, a} + {1'b0, b} + 17'd1; c = t[15:0]; f = t[16]; end
         OP_SUBC:        begin c = a - b - 16'd1; f = (a <= b); end
         default:        c = 16'h0000;
      endcase
      return {f, (a < b), c[15], (c == 16'h0000), c};
   endfunction

   function automatic logic writes_ref(input logic [3:0] op);
      return !(op == OP_CMP || op == OP_CMPR || op > OP_SUBC);
   endfunction

   always_comb {alu_flag, alu_low, alu_negative, alu_zero, alu_c} = alu_ref(alu_opcode, alu_a, alu_b);

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      logic [24:0] e;
      #4;
      if (rst_n && out_valid && out_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_output got result=%h dest=%h wr=%b required no output", out_result, out_dest, out_wr);
         end else begin
            e = exp_q.pop_front();
            if ({out_result, out_dest, out_wr, psr_flag, psr_low, psr_negative, psr_zero} !== e) begin
               failures++;
               $display("FAIL scoreboard got result=%h dest=%h wr=%b psr=%b%b%b%b required result=%h dest=%h wr=%b psr=%b",
                        out_result, out_dest, out_wr, psr_flag, psr_low, psr_negative, psr_zero,
                        e[24:9], e[8:5], e[4], e[3:0]);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   // Called at a falling edge; returns at the falling edge after acceptance.
   // ea/eb are the operands the ALU is expected to see (after forwarding).
   task automatic send(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] ea, input logic [15:0] eb, input logic [3:0] dest,
                       input logic wr, input logic wr_psr, input logic [3:0] srca, input logic [3:0] srcb);
      int          n;
      logic [19:0] r;
      in_valid  = 1'b1;
      in_opcode = op;
      in_a      = a;
      in_b      = b;
      in_dest   = dest;
      in_wr     = wr;
      in_wr_psr = wr_psr;
      in_srca   = srca;
      in_srcb   = srcb;
      #1;
      n = 0;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (!in_ready) begin
         checks++;
         failures++;
         $display("FAIL send_timeout in_ready=%b required 1 within 20 cycles", in_ready);
         in_valid = 1'b0;
      end else begin
         r = alu_ref(op, ea, eb);
         if (wr_psr)
            psr_m = r[19:16];
         exp_q.push_back({r[15:0], dest, wr & writes_ref(op), psr_m});
         @(posedge clk);
         @(negedge clk);
         in_valid = 1'b0;
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      out_ready = 1'b1;
      while (exp_q.size() != 0 && n < 30) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain_timeout pending=%0d required 0", exp_q.size());
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst_n     = 1'b0;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_opcode = OP_ADD;
      in_a      = 16'h0011;
      in_b      = 16'h0022;
      in_dest   = 4'h1;
      in_wr     = 1'b1;
      in_wr_psr = 1'b1;
      in_srca   = 4'hf;
      in_srcb   = 4'hf;
      psr_m     = 4'h0;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if ({in_ready, out_valid} !== 2'b10) begin
         failures++;
         $display("FAIL reset_handshake got in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
      end
      checks++;
      if ({out_result, out_dest, out_wr, psr_flag, psr_low, psr_negative, psr_zero} !== 25'h0) begin
         failures++;
         $display("FAIL reset_values got result=%h dest=%h wr=%b psr=%b%b%b%b required all 0",
                  out_result, out_dest, out_wr, psr_flag, psr_low, psr_negative, psr_zero);
      end
      in_valid = 1'b0;
      rst_n    = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_no_stale got out_valid=%b required 0", out_valid);
      end
   endtask

   task automatic test_cmp();
      send(OP_CMP, 16'd5, 16'd5, 16'd5, 16'd5, 4'h3, 1'b1, 1'b1, 4'hf, 4'hf);
      @(negedge clk);
      #1;
      checks++;
      if ({out_valid, out_wr, psr_zero} !== 3'b101) begin
         failures++;
         $display("FAIL cmp_gating got out_valid=%b out_wr=%b psr_zero=%b required 1 0 1", out_valid, out_wr, psr_zero);
      end
      @(negedge clk);
      send(OP_CMPR, 16'd2, 16'd9, 16'd2, 16'd9, 4'h4, 1'b1, 1'b0, 4'hf, 4'hf);
      send(4'hf, 16'd7, 16'd7, 16'd7, 16'd7, 4'h5, 1'b1, 1'b1, 4'hf, 4'hf);
      drain();
   endtask

   task automatic test_latency();
      send(OP_ADD, 16'd3, 16'd4, 16'd3, 16'd4, 4'h2, 1'b1, 1'b1, 4'hf, 4'hf);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL latency_x_stage got out_valid=%b required 0", out_valid);
      end
      @(negedge clk);
      #1;
      checks++;
      if ({out_valid, out_result, out_wr, psr_zero} !== {1'b1, 16'd7, 1'b1, 1'b0}) begin
         failures++;
         $display("FAIL latency_w_stage got valid=%b result=%h wr=%b psr_zero=%b required 1 0007 1 0",
                  out_valid, out_result, out_wr, psr_zero);
      end
      @(negedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL latency_consumed got out_valid=%b required 0", out_valid);
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++;
         if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL back_to_back_ready item=%0d got in_ready=%b required 1", i, in_ready);
         end
         send(OP_SUB, 16'(100 + i), 16'd1, 16'(100 + i), 16'd1, 4'(i), 1'b1, 1'b1, 4'hf, 4'hf);
      end
      drain();
   endtask

   task automatic test_backpressure();
      logic [21:0] snap;
      out_ready = 1'b0;
      send(OP_ADD, 16'h1000, 16'h0001, 16'h1000, 16'h0001, 4'h1, 1'b1, 1'b0, 4'hf, 4'hf);
      send(OP_XOR, 16'h00ff, 16'h0f0f, 16'h00ff, 16'h0f0f, 4'h2, 1'b1, 1'b1, 4'hf, 4'hf);
      in_valid  = 1'b1;
      in_opcode = OP_MOV;
      in_a      = 16'h0000;
      in_b      = 16'hbeef;
      in_dest   = 4'h3;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
         failures++;
         $display("FAIL backpressure_full got in_ready=%b required 0", in_ready);
      end
      snap = {out_valid, out_result, out_dest, out_wr};
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         checks++;
         if ({out_valid, out_result, out_dest, out_wr, in_ready} !== {snap, 1'b0} || snap[21] !== 1'b1) begin
            failures++;
            $display("FAIL backpressure_hold cycle=%0d got valid=%b result=%h dest=%h wr=%b in_ready=%b required %b 0",
                     i, out_valid, out_result, out_dest, out_wr, in_ready, snap);
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      send(OP_MOV, 16'h0000, 16'hbeef, 16'h0000, 16'hbeef, 4'h3, 1'b1, 1'b0, 4'hf, 4'hf);
      drain();
   endtask

   task automatic test_midop_reset();
      out_ready = 1'b0;
      send(OP_SUB, 16'd1, 16'd2, 16'd1, 16'd2, 4'h1, 1'b1, 1'b1, 4'hf, 4'hf);
      send(OP_ADD, 16'd5, 16'd5, 16'd5, 16'd5, 4'h2, 1'b1, 1'b1, 4'hf, 4'hf);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({in_ready, out_valid} !== 2'b10) begin
         failures++;
         $display("FAIL midop_reset_ports got in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
      end
      exp_q.delete();
      psr_m = 4'h0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++;
      if ({out_valid, out_result, psr_flag, psr_low, psr_negative, psr_zero} !== 21'h0) begin
         failures++;
         $display("FAIL midop_reset_clear got valid=%b result=%h psr=%b%b%b%b required 0 0000 0000",
                  out_valid, out_result, psr_flag, psr_low, psr_negative, psr_zero);
      end
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL midop_reset_stale got out_valid=%b required 0", out_valid);
      end
      @(negedge clk);
   endtask

   task automatic test_forwarding();
      out_ready = 1'b1;
      // X-stage match on operand a
      send(OP_ADD, 16'd1, 16'd1, 16'd1, 16'd1, 4'h1, 1'b1, 1'b0, 4'hf, 4'hf);
      send(OP_ADD, 16'd0, 16'd5, fwd_on ? 16'd2 : 16'd0, 16'd5, 4'h2, 1'b1, 1'b0, 4'h1, 4'hf);
      drain();
      // W-stage match on operand b
      send(OP_ADD, 16'd10, 16'd0, 16'd10, 16'd0, 4'h3, 1'b1, 1'b0, 4'hf, 4'hf);
      @(negedge clk);
      send(OP_ADD, 16'd1, 16'd0, 16'd1, fwd_on ? 16'd10 : 16'd0, 4'h6, 1'b1, 1'b0, 4'hf, 4'h3);
      drain();
      // X match beats W match for the same register
      send(OP_ADD, 16'd1, 16'd0, 16'd1, 16'd0, 4'h4, 1'b1, 1'b0, 4'hf, 4'hf);
      send(OP_ADD, 16'd2, 16'd0, 16'd2, 16'd0, 4'h4, 1'b1, 1'b0, 4'hf, 4'hf);
      send(OP_ADD, 16'd0, 16'd3, fwd_on ? 16'd2 : 16'd0, 16'd3, 4'h7, 1'b1, 1'b0, 4'h4, 4'hf);
      drain();
      // a compare never writes, so it is never forwarded
      send(OP_CMP, 16'd9, 16'd9, 16'd9, 16'd9, 4'h5, 1'b1, 1'b0, 4'hf, 4'hf);
      send(OP_ADD, 16'd2, 16'd0, 16'd2, 16'd0, 4'h6, 1'b1, 1'b0, 4'h5, 4'hf);
      drain();
   endtask

   task automatic test_random();
      logic [3:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      for (int i = 0; i < 30; i++) begin
         op = 4'($urandom_range(0, 15));
         a  = 16'($urandom_range(0, 65535));
         b  = 16'($urandom_range(0, 65535));
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         if (!in_ready)
            out_ready = 1'b1;
         send(op, a, b, a, b, 4'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 4'hf, 4'hf);
      end
      drain();
   endtask

   // ---------------- sequence ----------------
   initial begin
      test_reset();
      test_cmp();
      test_latency();
      test_back_to_back();
      test_backpressure();
      test_midop_reset();
      test_forwarding();
      test_random();
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL leftover_expected pending=%0d required 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
